truth_table_bist: RTL

TRUTH_TABLE_BIST -- requirements
Module: truth_table_bist

---
 rtl/truth_table_bist_pkg.sv | 14 +
 rtl/popcount16.sv | 15 +
 rtl/truth_table_bist.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/truth_table_bist_pkg.sv
// Shared definitions for the truth-table BIST: FSM state encoding and
// vector-count constants used by the controller.
package truth_table_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int unsigned VEC_COUNT = 32'd16;
   localparam logic [3:0]  LAST_VEC  = 4'(VEC_COUNT - 32'd1);

endpackage

// File: rtl/popcount16.sv
// Combinational population count of a 16-bit vector (result 0..16).
module popcount16 (
   input  logic [15:0] vec,
   output logic [4:0]  count
);

   // Sum every set bit of the input vector.
   always_comb begin
      count = 5'd0;
      for (int i = 0; i < 16; i++) begin
         count = count + {4'd0, vec[i]};
      end
   end

endmodule

// File: rtl/truth_table_bist.sv
// Exhaustive 4-input truth-table BIST. Walks {A,B,C,D} through all 16
// vectors, holds each for HOLD_CYCLES clocks, samples f on the last cycle
// of each hold window, and compares the captured table with EXPECTED.
module truth_table_bist
   import truth_table_bist_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 32'd20,
   parameter logic [15:0] EXPECTED    = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        A,
   output logic        B,
   output logic        C,
   output logic        D,
   input  logic        f,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature,
   output logic [4:0]  fail_count
);

   // Last hold-counter value of a window; f is sampled when it is reached.
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 32'd1);

   state_e      state_r;
   state_e      next_state_s;

   logic [3:0]  index_r;
   logic [3:0]  index_nxt_s;
   logic [7:0]  hold_r;
   logic [7:0]  hold_nxt_s;
   logic [3:0]  abcd_r;
   logic [3:0]  abcd_nxt_s;
   logic        busy_r;
   logic        busy_nxt_s;
   logic        done_r;
   logic        done_nxt_s;
   logic        pass_r;
   logic        pass_nxt_s;
   logic [15:0] signature_r;
   logic [15:0] signature_nxt_s;
   logic [4:0]  fail_count_r;
   logic [4:0]  fail_count_nxt_s;

   // The final table differs from the stored one only in bit 15, which is
   // captured on the very edge that enters DONE.
   logic [15:0] final_sig_s;
   logic [15:0] mismatch_s;
   logic [4:0]  mismatch_cnt_s;

   assign final_sig_s = {f, signature_r[14:0]};
   assign mismatch_s  = final_sig_s ^ EXPECTED;

   popcount16 u_popcount16 (
      .vec   (mismatch_s),
      .count (mismatch_cnt_s)
   );

   // Next-state and next-output decode for the three-state controller.
   always_comb begin
      next_state_s     = state_r;
      index_nxt_s      = index_r;
      hold_nxt_s       = hold_r;
      signature_nxt_s  = signature_r;
      abcd_nxt_s       = 4'b0000;
      busy_nxt_s       = 1'b0;
      done_nxt_s       = 1'b0;
      pass_nxt_s       = pass_r;
      fail_count_nxt_s = fail_count_r;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               next_state_s    = ST_DRIVE;
               index_nxt_s     = 4'd0;
               hold_nxt_s      = 8'd0;
               signature_nxt_s = 16'h0000;
               abcd_nxt_s      = 4'd0;
               busy_nxt_s      = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end

         ST_DRIVE: begin
            busy_nxt_s = 1'b1;
            abcd_nxt_s = index_r;
            if (hold_r == HOLD_LAST) begin
               signature_nxt_s[index_r] = f;
               hold_nxt_s               = 8'd0;
               if (index_r == LAST_VEC) begin
                  next_state_s     = ST_DONE;
                  busy_nxt_s       = 1'b0;
                  abcd_nxt_s       = 4'b0000;
                  done_nxt_s       = 1'b1;
                  pass_nxt_s       = (final_sig_s == EXPECTED);
                  fail_count_nxt_s = mismatch_cnt_s;
               end else begin
                  index_nxt_s = index_r + 4'd1;
                  abcd_nxt_s  = index_r + 4'd1;
               end
            end else begin
               hold_nxt_s = hold_r + 8'd1;
            end
         end

         ST_DONE: begin
            next_state_s = ST_IDLE;
         end

         default: begin
            next_state_s = ST_IDLE;
            index_nxt_s  = 4'd0;
            hold_nxt_s   = 8'd0;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Counters, captured table and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         index_r      <= 4'd0;
         hold_r       <= 8'd0;
         abcd_r       <= 4'b0000;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         signature_r  <= 16'h0000;
         fail_count_r <= 5'd0;
      end else begin
         index_r      <= index_nxt_s;
         hold_r       <= hold_nxt_s;
         abcd_r       <= abcd_nxt_s;
         busy_r       <= busy_nxt_s;
         done_r       <= done_nxt_s;
         pass_r       <= pass_nxt_s;
         signature_r  <= signature_nxt_s;
         fail_count_r <= fail_count_nxt_s;
      end
   end

   assign {A, B, C, D} = abcd_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign pass         = pass_r;
   assign signature    = signature_r;
   assign fail_count   = fail_count_r;

endmodule
